// File: rtl/boost_filter_nch.sv
// boost_filter_nch: N-channel 3x3 high-boost sharpening stage, 3-stage pipeline with global-enable backpressure
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake, in_ready = !out_valid | out_ready
//   pixel, p1..p8              centre pixel and eight neighbours, CH channels of DW bits
//   bypass, in_sof, in_eol     per-sample bypass and frame sideband, travel with the sample
//   out_valid/out_ready        output handshake
//   result, out_sof, out_eol   sharpened pixel and aligned sideband
//   sat_cnt, sat_clr           clamp event counter and its clear (only with BOOST_SATCNT_EN)
module boost_filter_nch #(
    parameter int CH     = 3,
    parameter int DW     = 8,
    parameter int K      = 1,
    parameter int KSHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] pixel,
    input  logic [CH*DW-1:0] p1,
    input  logic [CH*DW-1:0] p2,
    input  logic [CH*DW-1:0] p3,
    input  logic [CH*DW-1:0] p4,
    input  logic [CH*DW-1:0] p5,
    input  logic [CH*DW-1:0] p6,
    input  logic [CH*DW-1:0] p7,
    input  logic [CH*DW-1:0] p8,
    input  logic             bypass,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] result,
    output logic             out_sof,
    output logic             out_eol
`ifdef BOOST_SATCNT_EN
    ,
    output logic [15:0]      sat_cnt,
    input  logic             sat_clr
`endif
);
    localparam int W = CH * DW;
    localparam logic signed [DW+7:0] KS = (DW+8)'(K);

    logic                   en;
    logic                   s1_v, s1_byp, s1_sof, s1_eol;
    logic [W-1:0]           s1_p;
    logic [CH-1:0][DW+2:0]  s1_s;
    logic                   s2_v, s2_byp, s2_sof, s2_eol;
    logic [W-1:0]           s2_p;
    logic [CH-1:0][DW+7:0]  s2_m;
    logic [CH-1:0][DW+2:0]  sum_w;
    logic [CH-1:0][DW+7:0]  m_w;
    logic [W-1:0]           res_w;
`ifdef BOOST_SATCNT_EN
    logic [CH-1:0]          clamp_w;
`endif

    // every stage advances together; a stalled output freezes the whole pipe
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            logic [DW-1:0]        p, q;
            logic signed [DW+3:0] d;
            logic signed [DW+7:0] m, e;
            logic signed [DW+8:0] r;
            logic                 hi, lo;
            assign sum_w[c] = (DW+3)'(p1[c*DW +: DW]) + (DW+3)'(p2[c*DW +: DW])
                            + (DW+3)'(p3[c*DW +: DW]) + (DW+3)'(p4[c*DW +: DW])
                            + (DW+3)'(p5[c*DW +: DW]) + (DW+3)'(p6[c*DW +: DW])
                            + (DW+3)'(p7[c*DW +: DW]) + (DW+3)'(p8[c*DW +: DW]);
            assign p        = s1_p[c*DW +: DW];
            // 8*P is a pure shift of the registered centre pixel
            assign d        = $signed({1'b0, p, 3'b000}) - $signed({1'b0, s1_s[c]});
            assign m        = KS * $signed({{4{d[DW+3]}}, d});
            assign m_w[c]   = m;
            assign q        = s2_p[c*DW +: DW];
            assign e        = $signed(s2_m[c]) >>> KSHIFT;
            assign r        = $signed({9'd0, q}) + $signed({e[DW+7], e});
            assign lo       = r[DW+8];
            assign hi       = !r[DW+8] && (|r[DW+7:DW]);
            assign res_w[c*DW +: DW] = s2_byp ? q : lo ? '0 : hi ? '1 : r[DW-1:0];
`ifdef BOOST_SATCNT_EN
            assign clamp_w[c] = !s2_byp && (hi || lo);
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_byp    <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_p      <= '0;
            s1_s      <= '0;
            s2_v      <= 1'b0;
            s2_byp    <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eol    <= 1'b0;
            s2_p      <= '0;
            s2_m      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            result    <= '0;
        end else if (en) begin
            s1_v      <= in_valid;
            s1_byp    <= bypass;
            s1_sof    <= in_sof;
            s1_eol    <= in_eol;
            s1_p      <= pixel;
            s1_s      <= sum_w;
            s2_v      <= s1_v;
            s2_byp    <= s1_byp;
            s2_sof    <= s1_sof;
            s2_eol    <= s1_eol;
            s2_p      <= s1_p;
            s2_m      <= m_w;
            out_valid <= s2_v;
            out_sof   <= s2_sof;
            out_eol   <= s2_eol;
            result    <= res_w;
        end
    end

`ifdef BOOST_SATCNT_EN
    logic [16:0] add, sum;

    always_comb begin
        add = '0;
        for (int i = 0; i < CH; i++) add = add + 17'(clamp_w[i]);
        sum = {1'b0, sat_cnt} + add;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt <= '0;
        else if (sat_clr) sat_cnt <= '0;
        else if (en && s2_v) sat_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`endif
endmodule

// File: tb/tb_boost_filter_nch.sv
// tb_boost_filter_nch: directed scoreboard bench for boost_filter_nch (CH=3, DW=8, K=1, KSHIFT=0)
module tb_boost_filter_nch;
    localparam int W = 24;

    logic         clk = 0, rst_n = 0;
    logic         in_valid = 0, out_ready = 1, bypass = 0, in_sof = 0, in_eol = 0;
    logic [W-1:0] pixel = 0, p1 = 0, p2 = 0, p3 = 0, p4 = 0, p5 = 0, p6 = 0, p7 = 0, p8 = 0;
    logic         in_ready, out_valid, out_sof, out_eol;
    logic [W-1:0] result;
`ifdef BOOST_SATCNT_EN
    logic [15:0]  sat_cnt;
    logic         sat_clr = 0;
`endif

    boost_filter_nch #(.CH(3), .DW(8), .K(1), .KSHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pixel(pixel), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .bypass(bypass), .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_sof(out_sof), .out_eol(out_eol)
`ifdef BOOST_SATCNT_EN
        , .sat_cnt(sat_cnt), .sat_clr(sat_clr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         sof;
        logic         eol;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0, fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] v);
        return {3{v}};
    endfunction

    // monitor: the transfer happens at the next posedge, inputs are stable here
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious out_valid", {31'd0, out_valid}, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("result", result, mon_e.r);
                chk("out_sof", {31'd0, out_sof}, {31'd0, mon_e.sof});
                chk("out_eol", {31'd0, out_eol}, {31'd0, mon_e.eol});
                if (mon_e.acc >= 0) chk("latency", cyc - mon_e.acc, 32'd3);
            end
        end
        if (rst_n && out_valid && !out_ready) chk("in_ready stall", {31'd0, in_ready}, 32'd0);
    end

    task automatic send(input logic [W-1:0] px, input logic [8*W-1:0] nb, input logic byp,
                        input logic sf, input logic el, input logic [W-1:0] r, input bit lat);
        int t;
        t = 0;
        pixel = px;
        {p8, p7, p6, p5, p4, p3, p2, p1} = nb;
        bypass = byp;
        in_sof = sf;
        in_eol = el;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) q.push_back('{r, sf, el, lat ? cyc : -1});
        else chk("accept timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sp[10] = '{24'h102030, 24'h0A0B0C, 24'h202020, 24'hFF0001, 24'h646464,
                             24'h010203, 24'h1C1C1C, 24'h303030, 24'h0F0F0F, 24'h808080};
    logic [W-1:0] sn[10] = '{24'h102030, 24'h090B0D, 24'h1E2224, 24'hF00000, 24'h656565,
                             24'h000000, 24'h1C1C1C, 24'h2F2F2F, 24'h101010, 24'h828282};
    logic [W-1:0] sr[10] = '{24'h102030, 24'h120B04, 24'h301000, 24'hFF0009, 24'h5C5C5C,
                             24'h09121B, 24'h1C1C1C, 24'h383838, 24'h070707, 24'h707070};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset out_sof", {31'd0, out_sof}, 32'd0);
        chk("reset out_eol", {31'd0, out_eol}, 32'd0);
`ifdef BOOST_SATCNT_EN
        chk("reset sat_cnt", sat_cnt, 32'd0);
`endif
        rst_n = 1;
        @(posedge clk);
        #1;

        send(24'h404040, {8{24'h404040}}, 0, 1, 0, 24'h404040, 1);
        drain();
        send(24'h505050, {8{24'h4C4C4C}}, 0, 0, 1, 24'h707070, 1);
        drain();
`ifdef BOOST_SATCNT_EN
        chk("sat_cnt edge", sat_cnt, 32'd0);
`endif
        send(24'h801010, {8{24'h703030}}, 0, 0, 0, 24'hFF0000, 1);
        drain();
`ifdef BOOST_SATCNT_EN
        chk("sat_cnt clamp", sat_cnt, 32'd3);
`endif
        send(24'h505050, {8{24'h4C4C4C}}, 1, 0, 0, 24'h505050, 1);
        send(24'h801010, {8{24'h703030}}, 1, 0, 0, 24'h801010, 1);
        drain();
`ifdef BOOST_SATCNT_EN
        chk("sat_cnt bypass", sat_cnt, 32'd3);
`endif
        send(24'h202020, {rep(8'd35), rep(8'd34), rep(8'd33), rep(8'd32),
                          rep(8'd31), rep(8'd30), rep(8'd29), rep(8'd28)}, 0, 0, 0, 24'h242424, 1);
        drain();
        send(24'h505050, {8{24'h4C4C4C}}, 0, 1, 0, 24'h707070, 1);
        send(24'h801010, {8{24'h703030}}, 0, 0, 1, 24'hFF0000, 1);
        drain();
`ifdef BOOST_SATCNT_EN
        chk("sat_cnt back-to-back", sat_cnt, 32'd6);
`endif

        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(sp[i], {8{sn[i]}}, 0, i == 0, (i % 5) == 4, sr[i], 0);
                in_valid = 0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
`ifdef BOOST_SATCNT_EN
        chk("sat_cnt stream", sat_cnt, 32'd7);
`endif

        send(sp[0], {8{sn[0]}}, 0, 1, 0, sr[0], 0);
        send(sp[4], {8{sn[4]}}, 0, 0, 0, sr[4], 0);
        send(sp[5], {8{sn[5]}}, 0, 0, 1, sr[5], 0);
        in_valid = 0;
        chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid reset result", result, 32'd0);
`ifdef BOOST_SATCNT_EN
        chk("mid reset sat_cnt", sat_cnt, 32'd0);
`endif
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        send(24'h505050, {8{24'h4C4C4C}}, 0, 1, 1, 24'h707070, 1);
        drain();

`ifdef BOOST_SATCNT_EN
        send(24'h801010, {8{24'h703030}}, 0, 0, 0, 24'hFF0000, 1);
        drain();
        chk("sat_cnt pre-clear", sat_cnt, 32'd3);
        sat_clr = 1;
        @(posedge clk);
        #1 sat_clr = 0;
        chk("sat_cnt clear", sat_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
